// File: rtl/ysyx_24110026_ifu_pkg.sv
// Shared constants and FSM encoding for the ysyx_24110026 instruction fetch unit.
// The IFU_MISALIGN_CHECK_EN build macro enables misaligned-redirect fault reporting.
package ysyx_24110026_ifu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;
   localparam logic [XLEN-1:0] INST_ZERO    = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_OUT  = 2'd2,
      S_DROP = 2'd3
   } ifu_state_e;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return XLEN'(pc + PC_STEP);
   endfunction

endpackage

// File: rtl/ysyx_24110026_ifu_if.sv
// Fetch-unit bus: instruction-memory request/response, decoder hand-off and redirect.
// The master modport is the IFU side; the slave modport is memory + decoder + branch unit.
interface ysyx_24110026_ifu_if;
   import ysyx_24110026_ifu_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;

   logic            rsp_valid;
   logic [XLEN-1:0] rsp_data;

   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_misalign;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output req_valid, req_addr,
      input  req_ready,
      input  rsp_valid, rsp_data,
      output inst_valid, inst, inst_pc, inst_misalign,
      input  inst_ready,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready,
      output rsp_valid, rsp_data,
      input  inst_valid, inst, inst_pc, inst_misalign,
      output inst_ready,
      output redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ysyx_24110026_ifu.sv
// Single-outstanding instruction fetch unit: REQ -> WAIT -> OUT loop with redirect/DROP handling.
// Define IFU_MISALIGN_CHECK_EN to report misaligned redirect targets as faults instead of aligning them.
module ysyx_24110026_ifu
   import ysyx_24110026_ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
   input  logic                 clk,
   input  logic                 rst,
   ysyx_24110026_ifu_if.master  bus
);

   ifu_state_e      state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] inst_q;
   logic [XLEN-1:0] inst_pc_q;
   logic            inst_valid_q;
   logic            drop_q;
   logic            halt_q;
`ifdef IFU_MISALIGN_CHECK_EN
   logic            misalign_q;
`endif

   logic [XLEN-1:0] redir_pc_d;
   logic            redir_fault_d;
   logic            req_go;
   logic            req_fire;
   logic            rsp_stale;

   // Redirect target: either kept verbatim (fault-checked) or forced word-aligned.
   always_comb begin
      redir_pc_d    = bus.redirect_pc;
      redir_fault_d = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      redir_fault_d = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
      redir_pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif
   end

   // drop_q marks a response still in flight from an abandoned fetch; no new request until it drains.
   assign req_go    = (state_q == S_REQ) && !halt_q && !drop_q && !rst;
   assign req_fire  = req_go && bus.req_ready;
   assign rsp_stale = bus.rsp_valid && drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         inst_q       <= INST_ZERO;
         inst_pc_q    <= INST_ZERO;
         inst_valid_q <= 1'b0;
         drop_q       <= 1'b0;
         halt_q       <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         if (rsp_stale) begin
            drop_q <= 1'b0;
         end

         if (bus.redirect_valid) begin
            pc_q         <= redir_pc_d;
            halt_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            if (redir_fault_d) begin
               // Faulting target: present a synthetic zero instruction, never fetch it.
               state_q      <= S_OUT;
               inst_valid_q <= 1'b1;
               inst_q       <= INST_ZERO;
               inst_pc_q    <= redir_pc_d;
`ifdef IFU_MISALIGN_CHECK_EN
               misalign_q   <= 1'b1;
`endif
               unique case (state_q)
                  S_REQ:          if (req_fire)       drop_q <= 1'b1;
                  S_WAIT, S_DROP: if (!bus.rsp_valid) drop_q <= 1'b1;
                  S_OUT:          ;
               endcase
            end else begin
               unique case (state_q)
                  S_REQ:          state_q <= req_fire ? S_DROP : S_REQ;
                  S_WAIT, S_DROP: state_q <= bus.rsp_valid ? S_REQ : S_DROP;
                  S_OUT:          state_q <= S_REQ;
               endcase
            end
         end else begin
            unique case (state_q)
               S_REQ: begin
                  if (req_fire) begin
                     state_q <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (bus.rsp_valid) begin
                     inst_q       <= bus.rsp_data;
                     inst_pc_q    <= pc_q;
                     inst_valid_q <= 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
                     misalign_q   <= 1'b0;
`endif
                     state_q      <= S_OUT;
                  end
               end
               S_OUT: begin
                  if (bus.inst_ready) begin
                     inst_valid_q <= 1'b0;
                     state_q      <= S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
                     // After a delivered fault, park until the next redirect.
                     if (misalign_q) begin
                        halt_q <= 1'b1;
                     end else begin
                        pc_q <= pc_inc(pc_q);
                     end
`else
                     pc_q <= pc_inc(pc_q);
`endif
                  end
               end
               S_DROP: begin
                  if (bus.rsp_valid) begin
                     state_q <= S_REQ;
                  end
               end
            endcase
         end
      end
   end

   assign bus.req_valid  = req_go;
   assign bus.req_addr   = pc_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
   assign bus.inst_misalign = misalign_q;
`else
   assign bus.inst_misalign = 1'b0;
`endif

endmodule

// File: doc/ysyx_24110026_ifu.md
YSYX_24110026_IFU -- requirements
Module: ysyx_24110026_ifu

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h80000000, the first fetch address after reset.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL provide port req_valid, output, 1, instruction-memory request valid.
REQ-005 SHALL provide port req_ready, input, 1, memory accepts the request.
REQ-006 SHALL provide port req_addr, output, 32, fetch address.
REQ-007 SHALL provide port rsp_valid, input, 1, memory response valid, in order, one per accepted request.
REQ-008 SHALL provide port rsp_data, input, 32, fetched instruction word.
REQ-009 SHALL provide port inst_valid, output, 1, instruction available to the decoder.
REQ-010 SHALL provide port inst_ready, input, 1, decoder consumes the instruction.
REQ-011 SHALL provide port inst, output, 32, instruction to the decoder.
REQ-012 SHALL provide port inst_pc, output, 32, address of inst.
REQ-013 SHALL provide port inst_misalign, output, 1, inst_pc is a misaligned-fetch fault.
REQ-014 SHALL provide port redirect_valid, input, 1, one-cycle branch/jump redirect.
REQ-015 SHALL provide port redirect_pc, input, 32, redirect target.

Function
REQ-016 SHALL implement FSM states REQ, WAIT, OUT, DROP, with at most one request outstanding.
REQ-017 REQ: req_valid=1, req_addr=pc; req_valid&req_ready -> WAIT.
REQ-018 WAIT: rsp_valid -> capture rsp_data and pc into the output register -> OUT.
REQ-019 OUT: inst_valid=1, inst/inst_pc held stable; inst_valid&inst_ready -> pc<=pc+4, REQ (no bubble beyond the request round-trip).
REQ-020 Redirect SHALL take priority over every other event in the same cycle and SHALL set pc<=redirect_pc.
REQ-021 Redirect in REQ without handshake -> stay in REQ; req_addr SHALL show the new pc on the next cycle.
REQ-022 Redirect in REQ with handshake, or in WAIT -> DROP.
REQ-023 Redirect in OUT -> REQ; inst_valid SHALL drop next cycle; a simultaneous inst handshake SHALL NOT advance pc.
REQ-024 DROP: discard the next rsp_valid, then go to REQ; a further redirect in DROP updates pc and stays in DROP.
REQ-025 A response arriving in the same cycle as a redirect in WAIT SHALL be discarded, with transition to REQ instead of DROP.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-027 All outputs SHALL be registered or state-decoded; no combinational path from inst_ready to req_valid.

Reset
REQ-028 Asserting rst SHALL immediately force state REQ, pc=RESET_PC, inst=0, inst_pc=0, inst_misalign=0, inst_valid=0, and drop flag cleared.
REQ-029 During reset, req_valid SHALL be 0; it SHALL be 1 with req_addr=RESET_PC in the first cycle after deassertion.
REQ-030 A reset mid-request SHALL NOT require the memory to suppress its response; the first response after reset, if no request has been issued since, SHALL be ignored.

Configuration
REQ-031 With IFU_MISALIGN_CHECK_EN defined, a redirect_pc with bits [1:0]!=0 SHALL skip the fetch and enter OUT with inst=32'h0, inst_pc=redirect_pc, and inst_misalign=1.
REQ-032 In that fault case, after the handshake the IFU SHALL wait in REQ with req_valid=0 until the next redirect.
REQ-033 Without IFU_MISALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 0 and inst_misalign SHALL be tied to 0.

Structure
REQ-034 FSM state encodings, RESET_PC default, and NOP/zero constants SHALL reside in the shared defines package.
REQ-035 The block SHALL be flat; no sub-module is required.

Verification
REQ-036 Reset release with req_ready=1 and 1-cycle rsp: first req_addr=32'h80000000, then inst_valid with inst_pc=32'h80000000; next req_addr=32'h80000004.
REQ-037 inst_ready held 0 for 5 cycles: inst/inst_pc stable and no new request issued.
REQ-038 Redirect to 32'h80000100 while in WAIT: stale rsp discarded, next req_addr=32'h80000100, delivered inst_pc=32'h80000100.
REQ-039 Redirect to 32'h80000200 in OUT coinciding with inst_ready=1: next req_addr=32'h80000200, not pc+4.
REQ-040 Redirect to 32'h80000102 with the macro defined: inst_valid=1, inst_misalign=1, inst_pc=32'h80000102, and no request issued; without the macro, req_addr=32'h80000100.
REQ-041 rst asserted while in WAIT: outputs reset asynchronously, and a late rsp_valid is ignored.
